opb_sw_reg_slave: RTL and testbench

OPB_SW_REG_SLAVE -- requirements
Module: opb_sw_reg_slave

---
 rtl/opb_sw_reg_slave.sv | 83 ++++++++
 tb/tb_opb_sw_reg_slave.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/opb_sw_reg_slave.sv
// opb_sw_reg_slave: OPB slave with four RW control registers and four RO status registers.
module opb_sw_reg_slave #(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_FFFF
) (
  input  logic         OPB_Clk,
  input  logic         OPB_Rst_n,
  input  logic [0:31]  OPB_ABus,
  input  logic [0:3]   OPB_BE,
  input  logic [0:31]  OPB_DBus,
  input  logic         OPB_RNW,
  input  logic         OPB_select,
  input  logic         OPB_seqAddr,
  output logic [0:31]  Sl_DBus,
  output logic         Sl_xferAck,
  output logic         Sl_errAck,
  output logic         Sl_retry,
  output logic         Sl_toutSup,
  output logic [127:0] ctrl_regs,
  output logic [3:0]   ctrl_wr_stb,
  input  logic [127:0] status_in
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr, offset, data_q, dbus_q, dbus_d, rd_word, mask;
  logic [127:0] ctrl_q, ctrl_d;
  logic [3:0] be_q, stb_q, stb_d;
  logic [2:0] idx_q;
  logic hit, unm_q, rnw_q, ack_q, ack_d, err_q, err_d, wr, unused;
  assign addr = OPB_ABus;
  assign offset = addr - C_BASEADDR;
  assign hit = OPB_select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
  assign unused = ^{OPB_seqAddr, offset[1:0]};
  assign rd_word = idx_q[2] ? status_in[{idx_q[1:0], 5'd0} +: 32] : ctrl_q[{idx_q[1:0], 5'd0} +: 32];
  assign mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  // GAP is only reached through an ack, so the write commits on the edge ending the ack cycle
  assign wr = state_q == GAP && !rnw_q && !unm_q && !idx_q[2];
  assign stb_d = wr ? 4'b0001 << idx_q[1:0] : 4'd0;
  assign state_d = state_q == IDLE ? (hit ? BUSY : IDLE) : state_q == BUSY ? (OPB_select ? GAP : IDLE) : IDLE;
  assign ack_d = state_q == BUSY && OPB_select;
  assign err_d = ack_d && unm_q;
  assign dbus_d = ack_d && rnw_q && !unm_q ? rd_word : 32'd0;
  always_comb begin
    ctrl_d = ctrl_q;
    for (int n = 0; n < 4; n++)
      if (stb_d[n]) ctrl_d[32*n +: 32] = (ctrl_q[32*n +: 32] & ~mask) | (data_q & mask);
  end
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      stb_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dbus_q <= '0;
      idx_q <= '0;
      unm_q <= 1'b0;
      rnw_q <= 1'b0;
      be_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      stb_q <= stb_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dbus_q <= dbus_d;
      if (state_q == IDLE && hit) begin
        idx_q <= offset[4:2];
        unm_q <= |offset[31:5];
        rnw_q <= OPB_RNW;
        be_q <= OPB_BE;
        data_q <= OPB_DBus;
      end
    end
  assign Sl_DBus = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck = err_q;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign ctrl_regs = ctrl_q;
  assign ctrl_wr_stb = stb_q;
endmodule

// File: tb/tb_opb_sw_reg_slave.sv
// tb_opb_sw_reg_slave: directed and random OPB transfers checked against a register-map model.
module tb_opb_sw_reg_slave;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] HIGH = 32'h0100_FFFF;
  logic clk = 0, rst_n = 0;
  logic [0:31] OPB_ABus = '0, OPB_DBus = '0, Sl_DBus;
  logic [0:3] OPB_BE = '0;
  logic OPB_RNW = 0, OPB_select = 0, OPB_seqAddr = 0;
  logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [127:0] ctrl_regs, status_in = '0;
  logic [3:0] ctrl_wr_stb;
  logic [31:0] m [4];
  int checks = 0, errors = 0;

  opb_sw_reg_slave #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH)) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus),
    .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus),
    .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .ctrl_regs(ctrl_regs), .ctrl_wr_stb(ctrl_wr_stb), .status_in(status_in));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one transfer from a negedge; returns ack latency in edges after the hit edge (-1 = none).
  task automatic xfer(input logic [31:0] a, input logic rnw, input logic [0:3] be, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic err, output logic [3:0] stb);
    OPB_ABus = a; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = d; OPB_select = 1;
    lat = -1; rd = 0; err = 0;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (Sl_xferAck) begin lat = c; rd = Sl_DBus; err = Sl_errAck; end
      else chk("idle_dbus", 128'(Sl_DBus), 0);
    end
    OPB_select = 0;
    @(posedge clk); @(negedge clk);
    stb = ctrl_wr_stb;
    chk("post_ack", 128'({Sl_xferAck, Sl_errAck, Sl_DBus}), 0);
  endtask

  task automatic txn(input logic [31:0] a, input logic rnw, input logic [0:3] be, input logic [31:0] d);
    logic [31:0] off, exp_rd, rd;
    logic [3:0] exp_stb, stb;
    logic in_win, unm, err;
    int idx, lat;
    in_win = a >= BASE && a <= HIGH;
    off = a - BASE;
    unm = off >= 32'h20;
    idx = int'(off[4:2]);
    exp_rd = 0; exp_stb = 0;
    if (in_win && !unm) begin
      if (rnw) exp_rd = idx < 4 ? m[idx] : status_in[32*(idx-4) +: 32];
      else if (idx < 4) begin
        for (int i = 0; i < 4; i++) if (be[i]) m[idx][31-8*i -: 8] = d[31-8*i -: 8];
        exp_stb[idx] = 1'b1;
      end
    end
    xfer(a, rnw, be, d, lat, rd, err, stb);
    chk("latency", 128'(lat), in_win ? 128'd1 : {128{1'b1}});
    chk("errack", 128'(err), 128'(in_win && unm));
    chk("rdata", 128'(rd), 128'(exp_rd));
    chk("wr_stb", 128'(stb), 128'(exp_stb));
    chk("regs", ctrl_regs, {m[3], m[2], m[1], m[0]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    int acks [3];
    logic [31:0] a;
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (2) @(negedge clk);
    chk("reset_out", {Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, ctrl_wr_stb, Sl_DBus}, 0);
    chk("reset_regs", ctrl_regs, 0);
    rst_n = 1;
    @(negedge clk);
    // write/readback of reg1, strobe exactly one cycle
    txn(BASE + 32'h04, 0, 4'b1111, 32'hDEADBEEF);
    @(negedge clk);
    chk("stb_one_cycle", 128'(ctrl_wr_stb), 0);
    txn(BASE + 32'h04, 1, 4'b0000, 0);
    chk("reg1_direct", 128'(ctrl_regs[63:32]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    // partial byte-enable write
    txn(BASE, 0, 4'b1111, 32'h11223344);
    txn(BASE, 0, 4'b0101, 32'hAABBCCDD);
    txn(BASE, 0, 4'b0000, 32'hFFFFFFFF);
    // status registers are read-only
    status_in[63:32] = 32'h12345678;
    txn(BASE + 32'h14, 1, 4'b1111, 0);
    txn(BASE + 32'h14, 0, 4'b1111, 0);
    txn(BASE + 32'h14, 1, 4'b0000, 0);
    // unmapped and out-of-window
    txn(BASE + 32'h40, 1, 4'b1111, 0);
    txn(BASE + 32'h40, 0, 4'b1111, 32'h5A5A5A5A);
    txn(HIGH + 32'd4, 1, 4'b1111, 0);
    // master abort in BUSY
    OPB_ABus = BASE + 32'h0C; OPB_RNW = 0; OPB_BE = 4'b1111; OPB_DBus = 32'hCAFEF00D; OPB_select = 1;
    @(posedge clk); @(negedge clk);
    OPB_select = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_ack", 128'({Sl_xferAck, Sl_errAck, ctrl_wr_stb}), 0);
    end
    chk("abort_regs", ctrl_regs, {m[3], m[2], m[1], m[0]});
    // back-to-back writes with select held
    OPB_ABus = BASE + 32'h08; OPB_RNW = 0; OPB_BE = 4'b1111; OPB_DBus = $urandom; OPB_select = 1;
    k = 0;
    acks = '{0, 0, 0};
    for (int c = 0; c < 12 && k < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("b2b_dbus", 128'(Sl_DBus), 0);
      if (Sl_xferAck) begin
        acks[k] = c; m[2] = OPB_DBus; k++; OPB_DBus = $urandom;
        if (k == 3) OPB_select = 0;
      end
    end
    chk("b2b_count", 128'(k), 3);
    chk("b2b_first", 128'(acks[0]), 1);
    chk("b2b_gap1", 128'(acks[1] - acks[0]), 3);
    chk("b2b_gap2", 128'(acks[2] - acks[1]), 3);
    @(posedge clk); @(negedge clk);
    chk("b2b_regs", ctrl_regs, {m[3], m[2], m[1], m[0]});
    // random traffic
    for (int t = 0; t < 60; t++) begin
      status_in = {$urandom, $urandom, $urandom, $urandom};
      k = $urandom_range(0, 11);
      a = k == 0 ? HIGH + 32'd4 : k == 1 ? BASE - 32'd4 : k == 2 ? BASE + 32'($urandom_range(32'h20, 32'hFFFF))
          : BASE + 32'($urandom_range(0, 31));
      txn(a, 1'($urandom), 4'($urandom), $urandom);
    end
    // reset while BUSY: outputs clear at once, no write
    chk("pre_reset_nonzero", 128'(ctrl_regs != 0), 1);
    OPB_ABus = BASE + 32'h08; OPB_RNW = 0; OPB_BE = 4'b1111; OPB_DBus = 32'h0BADF00D; OPB_select = 1;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = 0;
    chk("rst_busy_out", 128'({Sl_xferAck, Sl_errAck, ctrl_wr_stb, Sl_DBus}), 0);
    chk("rst_busy_regs", ctrl_regs, 0);
    @(negedge clk);
    OPB_select = 0;
    @(negedge clk);
    rst_n = 1;
    txn(BASE + 32'h08, 1, 4'b1111, 0);
    txn(BASE + 32'h0C, 0, 4'b1001, 32'h87654321);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
